// File: rtl/benes_cfg_sequencer.sv
// Benes interconnect configuration sequencer: holds module/slot select tables and,
// per accepted command, drives both networks' switch selects for a burst of data beats.
module benes_cfg_sequencer #(
    parameter int STAGE_NUM  = 9,
    parameter int SWITCH_NUM = 16,
    parameter int CFG_DEPTH  = 16,
    parameter int DRAIN_CYC  = 11,
    localparam int CFG_AW    = $clog2(CFG_DEPTH),
    localparam int WORD_W    = STAGE_NUM * SWITCH_NUM
) (
    input  logic                                      CLK,
    input  logic                                      RST_N,
    input  logic                                      CFG_WE,
    input  logic                                      CFG_WSEL,
    input  logic [CFG_AW-1:0]                         CFG_WADDR,
    input  logic [WORD_W-1:0]                         CFG_WDATA,
    input  logic                                      CMD_VALID,
    output logic                                      CMD_READY,
    input  logic [CFG_AW-1:0]                         CMD_MOD_IDX,
    input  logic [CFG_AW-1:0]                         CMD_SLOT_IDX,
    input  logic [7:0]                                CMD_BEATS,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]      O_MODULE_SELECT,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]      O_SLOT_SELECT,
    output logic                                      O_DATA_EN,
    output logic                                      O_BUSY,
    output logic                                      O_DONE
);

    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = DRAIN_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                                   state_r;
    state_t                                   state_next_s;
    logic [8:0]                               beat_cnt_r;
    logic [8:0]                               beat_cnt_next_s;
    logic [DRAIN_W-1:0]                       drain_cnt_r;
    logic [DRAIN_W-1:0]                       drain_cnt_next_s;
    logic [CFG_AW-1:0]                        mod_idx_r;
    logic [CFG_AW-1:0]                        slot_idx_r;
    logic                                     handshake_s;

    logic [WORD_W-1:0]                        mod_tbl [CFG_DEPTH];
    logic [WORD_W-1:0]                        slot_tbl [CFG_DEPTH];
    logic [WORD_W-1:0]                        mod_word_s;
    logic [WORD_W-1:0]                        slot_word_s;
    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     mod_sel_s;
    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     slot_sel_s;

    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     mod_sel_r;
    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     slot_sel_r;
    logic                                     data_en_r;
    logic                                     busy_r;
    logic                                     done_r;
    logic                                     ready_r;

    assign handshake_s = CMD_VALID & ready_r;

    // Configuration tables: writable in any state, never reset.
    always_ff @(posedge CLK) begin
        if (CFG_WE) begin
            if (CFG_WSEL == 1'b0) begin
                mod_tbl[CFG_WADDR] <= CFG_WDATA;
            end else begin
                slot_tbl[CFG_WADDR] <= CFG_WDATA;
            end
        end
    end

    assign mod_word_s  = mod_tbl[mod_idx_r];
    assign slot_word_s = slot_tbl[slot_idx_r];

    // Unpack table words: word bit s*SWITCH_NUM+w drives stage s, switch w.
    always_comb begin
        mod_sel_s  = '0;
        slot_sel_s = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            for (int w = 0; w < SWITCH_NUM; w++) begin
                mod_sel_s[s][w]  = mod_word_s[s*SWITCH_NUM + w];
                slot_sel_s[s][w] = slot_word_s[s*SWITCH_NUM + w];
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next_s     = state_r;
        beat_cnt_next_s  = beat_cnt_r;
        drain_cnt_next_s = drain_cnt_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    state_next_s    = LOAD;
                    beat_cnt_next_s = (CMD_BEATS == 8'd0) ? 9'd256 : {1'b0, CMD_BEATS};
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = ISSUE;
            end
            ISSUE: begin
                if (beat_cnt_r == 9'd1) begin
                    state_next_s     = DRAIN;
                    beat_cnt_next_s  = 9'd0;
                    drain_cnt_next_s = DRAIN_LOAD;
                end else begin
                    beat_cnt_next_s = beat_cnt_r - 9'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_ONE) begin
                    state_next_s     = IDLE;
                    drain_cnt_next_s = DRAIN_ZERO;
                end else begin
                    drain_cnt_next_s = drain_cnt_r - DRAIN_ONE;
                end
            end
            default: begin
                state_next_s     = IDLE;
                beat_cnt_next_s  = 9'd0;
                drain_cnt_next_s = DRAIN_ZERO;
            end
        endcase
    end

    // State, counters, latched command and registered status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            beat_cnt_r  <= 9'd0;
            drain_cnt_r <= DRAIN_ZERO;
            mod_idx_r   <= '0;
            slot_idx_r  <= '0;
            data_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            beat_cnt_r  <= beat_cnt_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            if (handshake_s) begin
                mod_idx_r  <= CMD_MOD_IDX;
                slot_idx_r <= CMD_SLOT_IDX;
            end
            data_en_r <= (state_next_s == ISSUE);
            busy_r    <= (state_next_s != IDLE);
            ready_r   <= (state_next_s == IDLE);
            // Done is computed one cycle early so it lands on the final drain cycle.
            done_r    <= (state_next_s == DRAIN) && (drain_cnt_next_s == DRAIN_ONE);
        end
    end

    // Select registers: the table read happens on the LOAD->ISSUE edge only,
    // so a same-edge table write is seen as old data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mod_sel_r  <= '0;
            slot_sel_r <= '0;
        end else if (state_r == LOAD) begin
            mod_sel_r  <= mod_sel_s;
            slot_sel_r <= slot_sel_s;
        end
    end

    assign CMD_READY       = ready_r;
    assign O_MODULE_SELECT = mod_sel_r;
    assign O_SLOT_SELECT   = slot_sel_r;
    assign O_DATA_EN       = data_en_r;
    assign O_BUSY          = busy_r;
    assign O_DONE          = done_r;

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Directed, table-driven bench for benes_cfg_sequencer: cycle-exact command timeline checks.
module tb_benes_cfg_sequencer;

    localparam int S  = 9;
    localparam int W  = 16;
    localparam int WW = S * W;
    localparam int D  = 11;

    logic                     CLK = 1'b0;
    logic                     RST_N;
    logic                     CFG_WE;
    logic                     CFG_WSEL;
    logic [3:0]               CFG_WADDR;
    logic [WW-1:0]            CFG_WDATA;
    logic                     CMD_VALID;
    logic                     CMD_READY;
    logic [3:0]               CMD_MOD_IDX;
    logic [3:0]               CMD_SLOT_IDX;
    logic [7:0]               CMD_BEATS;
    logic [0:S-1][0:W-1]      O_MODULE_SELECT;
    logic [0:S-1][0:W-1]      O_SLOT_SELECT;
    logic                     O_DATA_EN;
    logic                     O_BUSY;
    logic                     O_DONE;

    int nvec  = 0;
    int nfail = 0;

    benes_cfg_sequencer #(
        .STAGE_NUM(S), .SWITCH_NUM(W), .CFG_DEPTH(16), .DRAIN_CYC(D)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CFG_WE(CFG_WE), .CFG_WSEL(CFG_WSEL), .CFG_WADDR(CFG_WADDR), .CFG_WDATA(CFG_WDATA),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_MOD_IDX(CMD_MOD_IDX), .CMD_SLOT_IDX(CMD_SLOT_IDX), .CMD_BEATS(CMD_BEATS),
        .O_MODULE_SELECT(O_MODULE_SELECT), .O_SLOT_SELECT(O_SLOT_SELECT),
        .O_DATA_EN(O_DATA_EN), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]    mod_idx;
        logic [3:0]    slot_idx;
        logic [7:0]    beats;
        bit            hold;
        int            wr_k;
        logic          wr_sel;
        logic [3:0]    wr_addr;
        logic [WW-1:0] wr_data;
        logic [WW-1:0] exp_mod;
        logic [WW-1:0] exp_slot;
    } vec_t;

    function automatic logic [WW-1:0] flat(input logic [0:S-1][0:W-1] x);
        logic [WW-1:0] r;
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++)
                r[s*W + w] = x[s][w];
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] m, input logic [3:0] sl, input logic [7:0] b,
                                input bit h, input int wk, input logic ws, input logic [3:0] wa,
                                input logic [WW-1:0] wd, input logic [WW-1:0] em,
                                input logic [WW-1:0] es);
        vec_t v;
        v.mod_idx = m;  v.slot_idx = sl; v.beats = b; v.hold = h;
        v.wr_k = wk;    v.wr_sel = ws;   v.wr_addr = wa; v.wr_data = wd;
        v.exp_mod = em; v.exp_slot = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic sel, input logic [3:0] addr, input logic [WW-1:0] data);
        @(negedge CLK);
        CFG_WE = 1'b1; CFG_WSEL = sel; CFG_WADDR = addr; CFG_WDATA = data;
        @(negedge CLK);
        CFG_WE = 1'b0;
    endtask

    // Drives one command and checks every cycle from handshake to return to IDLE.
    task automatic run_cmd(input vec_t v);
        int n, last, guard;
        logic [3:0] exp_st;
        n    = (v.beats == 8'd0) ? 256 : int'(v.beats);
        last = n + D + 2;
        guard = 0;
        while (CMD_READY !== 1'b1 && guard < 400) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 400) begin
            nvec++; nfail++;
            $display("FAIL ready_timeout: got READY=%b expected 1", CMD_READY);
            return;
        end
        CMD_VALID = 1'b1; CMD_MOD_IDX = v.mod_idx; CMD_SLOT_IDX = v.slot_idx; CMD_BEATS = v.beats;
        @(posedge CLK);
        for (int k = 1; k <= last; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                if (!v.hold) CMD_VALID = 1'b0;
                CMD_MOD_IDX  = v.mod_idx + 4'd1;
                CMD_SLOT_IDX = v.slot_idx + 4'd1;
                CMD_BEATS    = v.beats + 8'd1;
            end
            exp_st[3] = (k >= 2) && (k <= n + 1);
            exp_st[2] = (k <= n + D + 1);
            exp_st[1] = (k == last);
            exp_st[0] = (k == n + D + 1);
            check($sformatf("status k=%0d {en,busy,rdy,done}", k),
                  WW'({O_DATA_EN, O_BUSY, CMD_READY, O_DONE}), WW'(exp_st));
            if (k == 2 || k == last) begin
                check($sformatf("mod_sel k=%0d", k), flat(O_MODULE_SELECT), v.exp_mod);
                check($sformatf("slot_sel k=%0d", k), flat(O_SLOT_SELECT), v.exp_slot);
            end
            if (k == v.wr_k) begin
                CFG_WE = 1'b1; CFG_WSEL = v.wr_sel; CFG_WADDR = v.wr_addr; CFG_WDATA = v.wr_data;
            end else begin
                CFG_WE = 1'b0;
            end
        end
        CFG_WE = 1'b0;
    endtask

    logic [WW-1:0] all1, zero, p5, pa, pat1, pat2;
    vec_t vecs[9];
    vec_t vr;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        all1 = '1; zero = '0;
        p5 = {36{4'h5}}; pa = {36{4'hA}};
        for (int s = 0; s < S; s++) pat1[s*W +: W] = {8'(s + 1), 8'hC3 ^ 8'(s)};
        pat2 = {pat1[7:0], pat1[WW-1:8]};

        vecs[0] = mk(4'd3, 4'd5, 8'd4, 1'b0, 0, 1'b0, 4'd0, zero, all1, p5);
        vecs[1] = mk(4'd3, 4'd5, 8'd1, 1'b0, 0, 1'b0, 4'd0, zero, all1, p5);
        vecs[2] = mk(4'd3, 4'd5, 8'd0, 1'b0, 0, 1'b0, 4'd0, zero, all1, p5);
        vecs[3] = mk(4'd7, 4'd2, 8'd3, 1'b0, 3, 1'b0, 4'd7, pat2, pat1, pa);
        vecs[4] = mk(4'd7, 4'd2, 8'd2, 1'b0, 0, 1'b0, 4'd0, zero, pat2, pa);
        vecs[5] = mk(4'd3, 4'd2, 8'd2, 1'b0, 1, 1'b1, 4'd2, pat1, all1, pa);
        vecs[6] = mk(4'd3, 4'd2, 8'd2, 1'b0, 0, 1'b0, 4'd0, zero, all1, pat1);
        vecs[7] = mk(4'd7, 4'd5, 8'd2, 1'b1, 0, 1'b0, 4'd0, zero, pat2, p5);
        vecs[8] = mk(4'd3, 4'd2, 8'd3, 1'b0, 0, 1'b0, 4'd0, zero, all1, pat1);

        RST_N = 1'b0; CFG_WE = 1'b0; CFG_WSEL = 1'b0; CFG_WADDR = 4'd0; CFG_WDATA = '0;
        CMD_VALID = 1'b0; CMD_MOD_IDX = 4'd0; CMD_SLOT_IDX = 4'd0; CMD_BEATS = 8'd0;
        repeat (3) @(negedge CLK);
        check("reset mod_sel", flat(O_MODULE_SELECT), zero);
        check("reset slot_sel", flat(O_SLOT_SELECT), zero);
        check("reset {en,busy,done}", WW'({O_DATA_EN, O_BUSY, O_DONE}), WW'(3'b000));
        RST_N = 1'b1;
        @(negedge CLK);
        check("post-reset {en,busy,rdy,done}", WW'({O_DATA_EN, O_BUSY, CMD_READY, O_DONE}),
              WW'(4'b0010));

        cfg_write(1'b0, 4'd3, all1);
        cfg_write(1'b1, 4'd5, p5);
        cfg_write(1'b0, 4'd7, pat1);
        cfg_write(1'b1, 4'd2, pa);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Reset in the middle of ISSUE aborts the command with no DONE.
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_MOD_IDX = 4'd3; CMD_SLOT_IDX = 4'd5; CMD_BEATS = 8'd8;
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("mid-issue en before reset", WW'(O_DATA_EN), WW'(1'b1));
        #2 RST_N = 1'b0;
        #1;
        check("abort mod_sel", flat(O_MODULE_SELECT), zero);
        check("abort slot_sel", flat(O_SLOT_SELECT), zero);
        check("abort {en,busy,done}", WW'({O_DATA_EN, O_BUSY, O_DONE}), WW'(3'b000));
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge CLK);
            check($sformatf("after abort k=%0d {en,busy,rdy,done}", k),
                  WW'({O_DATA_EN, O_BUSY, CMD_READY, O_DONE}), WW'(4'b0010));
        end
        vr = mk(4'd3, 4'd5, 8'd2, 1'b0, 0, 1'b0, 4'd0, zero, all1, p5);
        run_cmd(vr);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/benes_cfg_sequencer.md
BENES_CFG_SEQUENCER -- requirements
Module: benes_cfg_sequencer

Interface
REQ-001 SHALL have parameter STAGE_NUM, 9, Benes stage count (2*log2(PORT_NUM)-1).
REQ-002 SHALL have parameter SWITCH_NUM, 16, 2x2 switches per stage.
REQ-003 SHALL have parameter CFG_DEPTH, 16, entries per configuration table; CFG_AW = log2(CFG_DEPTH).
REQ-004 SHALL have parameter DRAIN_CYC, 11, cycles selects are held after the last beat (interconnect latency).
REQ-005 SHALL use reset RST_N, asynchronous, active-low; clock CLK.
REQ-006 CLK  input  1  clock.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 CFG_WE  input  1  table write strobe.
REQ-009 CFG_WSEL  input  1  0 = module-select table, 1 = slot-select table.
REQ-010 CFG_WADDR  input  CFG_AW  table write address.
REQ-011 CFG_WDATA  input  STAGE_NUM*SWITCH_NUM  switch word; bit s*SWITCH_NUM+w = stage s, switch w.
REQ-012 CMD_VALID  input  1  permutation command valid.
REQ-013 CMD_READY  output  1  command accepted when VALID and READY both high.
REQ-014 CMD_MOD_IDX  input  CFG_AW  module-select table entry.
REQ-015 CMD_SLOT_IDX  input  CFG_AW  slot-select table entry.
REQ-016 CMD_BEATS  input  8  data beats under this config; 0 encodes 256.
REQ-017 O_MODULE_SELECT  output  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  to RAM-to-module network.
REQ-018 O_SLOT_SELECT  output  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  to module-to-RAM network.
REQ-019 O_DATA_EN  output  1  high on each cycle RAM/module data may be launched into the interconnect.
REQ-020 O_BUSY  output  1  high whenever state is not IDLE.
REQ-021 O_DONE  output  1  one-cycle pulse at end of DRAIN.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, ISSUE, DRAIN; CMD_READY = (state==IDLE).
REQ-023 Handshake at cycle T: IDX and BEATS latched; T+1 LOAD performs registered read of both tables.
REQ-024 At T+2 state ISSUE; both select outputs update from the read data and O_DATA_EN goes high.
REQ-025 O_DATA_EN SHALL be high for exactly N consecutive cycles (N = CMD_BEATS, 0->256), beat counter 9 bits.
REQ-026 After the last beat, DRAIN holds selects with O_DATA_EN low for exactly DRAIN_CYC cycles.
REQ-027 O_DONE pulses on the final DRAIN cycle; next cycle IDLE, CMD_READY high.
REQ-028 Select outputs SHALL change only on LOAD->ISSUE; they retain their value through DRAIN and IDLE.
REQ-029 Table writes SHALL be accepted in any state; active outputs are unaffected by writes after LOAD.
REQ-030 Write and LOAD read of same entry in same cycle SHALL return old data (read-before-write).
REQ-031 CMD_VALID while not IDLE SHALL be ignored; command inputs sampled only at handshake.
REQ-032 Minimum command-to-command period SHALL be N + DRAIN_CYC + 2 cycles.

Reset
REQ-033 On RST_N low, asynchronously: state IDLE, counters 0, O_MODULE_SELECT=0, O_SLOT_SELECT=0, O_DATA_EN=0, O_BUSY=0, O_DONE=0.
REQ-034 CMD_READY SHALL be high from the first cycle after RST_N deasserts.
REQ-035 Table contents are not reset; reset mid-ISSUE/DRAIN aborts without O_DONE.

Verification
REQ-036 Write mod entry 3 = all-ones, slot entry 5 = 0x5...5; cmd(3,5,BEATS=4) at T -> selects valid T+2, DATA_EN high T+2..T+5, DONE at T+5+DRAIN_CYC, READY T+6+DRAIN_CYC.
REQ-037 CMD_BEATS=0 -> exactly 256 DATA_EN cycles; CMD_BEATS=1 -> single-cycle DATA_EN.
REQ-038 Overwrite active entry during ISSUE -> outputs unchanged; next command on same entry shows new data.
REQ-039 Same-cycle write/LOAD of same entry -> old word on outputs.
REQ-040 CMD_VALID held high through busy -> exactly one acceptance per IDLE; no lost or duplicate command.
REQ-041 RST_N low mid-ISSUE -> all outputs 0 immediately, no DONE, READY high after release.
